// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: register index width, hazard FSM states and
// the NOP encoding loaded into IF/ID on a flush.
package mips_pkg;

    localparam int REG_W = 5;

    // sll $0,$0,0 encodes as all zeros
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2,
        ST_FLUSH = 2'd3
    } hz_state_t;

    // Which priority case governs the controls in the current cycle
    typedef enum logic [2:0] {
        CASE_INIT,
        CASE_BUSY,
        CASE_BRANCH,
        CASE_HAZARD,
        CASE_NORMAL
    } hz_case_t;

endpackage

// File: rtl/mips_hazard_detect.sv
// Combinational load-use compare between the instruction in decode and a load in ex.
// Kept standalone so the forwarding unit can share the same compare.
module mips_hazard_detect
    import mips_pkg::*;
#(
    parameter int REG_W = mips_pkg::REG_W
) (
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    output logic             hazard_lu
);

    logic rs_match;
    logic rt_match;

    assign rs_match = (ex_rt == id_rs);
    assign rt_match = id_uses_rt && (ex_rt == id_rt);

    // $zero is never a real producer, so a load targeting it cannot cause a hazard
    assign hazard_lu = ex_mem_read && (ex_rt != '0) && (rs_match || rt_match);

endmodule

// File: rtl/mips_hazard_ctrl.sv
// Pipeline hazard/sequencing controller: init hold, memory-busy freeze, taken-branch
// squash and load-use stall. Define MIPS_HAZARD_PERF_EN to build the stall/flush counters.
module mips_hazard_ctrl
    import mips_pkg::*;
#(
    parameter int INIT_HOLD = 2,
    parameter int REG_W     = mips_pkg::REG_W,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             mem_pc_src,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             exmem_flush,
    output logic             pipe_freeze,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    hz_state_t  cur_state;
    hz_case_t   act_case;
    logic [3:0] hold_cnt;
    logic       hazard_lu;

    mips_hazard_detect #(.REG_W(REG_W)) u_detect (
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .ex_mem_read (ex_mem_read),
        .ex_rt       (ex_rt),
        .hazard_lu   (hazard_lu)
    );

    // NOTE: every output gets a default before the case so no path leaves a latch.
    always_comb begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        exmem_flush = 1'b0;
        pipe_freeze = 1'b0;

        if (cur_state == ST_INIT) act_case = CASE_INIT;
        else if (mem_busy)        act_case = CASE_BUSY;
        else if (mem_pc_src)      act_case = CASE_BRANCH;
        else if (hazard_lu)       act_case = CASE_HAZARD;
        else                      act_case = CASE_NORMAL;

        case (act_case)
            CASE_INIT: begin
                ifid_write  = 1'b1;
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                exmem_flush = 1'b1;
            end
            CASE_BUSY: begin
                pipe_freeze = 1'b1;
            end
            CASE_BRANCH: begin
                // fetch loads the branch target on the same edge the younger stages squash
                pc_write    = 1'b1;
                ifid_write  = 1'b1;
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                exmem_flush = 1'b1;
            end
            CASE_HAZARD: begin
                idex_bubble = 1'b1;
            end
            default: begin
                pc_write   = 1'b1;
                ifid_write = 1'b1;
            end
        endcase
    end

    // NOTE: reset is synchronous, so it is tested inside the clocked block; all state uses <=.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_state <= ST_INIT;
            hold_cnt  <= 4'd0;
        end else begin
            case (act_case)
                CASE_INIT: begin
                    if (hold_cnt == 4'(INIT_HOLD - 1)) cur_state <= ST_RUN;
                    if (hold_cnt != 4'hF) hold_cnt <= hold_cnt + 4'd1;
                end
                CASE_BUSY:   cur_state <= cur_state;
                CASE_BRANCH: cur_state <= ST_FLUSH;
                CASE_HAZARD: cur_state <= ST_STALL;
                default:     cur_state <= ST_RUN;
            endcase
        end
    end

    assign state = cur_state;

`ifdef MIPS_HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (act_case == CASE_HAZARD) stall_q <= stall_q + 1'b1;
            if (act_case == CASE_BRANCH) flush_q <= flush_q + 1'b1;
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_mips_hazard_ctrl.sv
// Scoreboard bench for mips_hazard_ctrl: directed test-plan sequences followed by
// random traffic, checked against a behavioural model of the hazard rules.
module tb_mips_hazard_ctrl;

    localparam int INIT_HOLD = 2;
    localparam int REG_W     = 5;
    localparam int CNT_W     = 16;

    logic             clk;
    logic             rst_n;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_uses_rt;
    logic             ex_mem_read;
    logic [REG_W-1:0] ex_rt;
    logic             mem_pc_src;
    logic             mem_busy;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             exmem_flush;
    logic             pipe_freeze;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    mips_hazard_ctrl #(
        .INIT_HOLD (INIT_HOLD),
        .REG_W     (REG_W),
        .CNT_W     (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .ex_mem_read (ex_mem_read),
        .ex_rt       (ex_rt),
        .mem_pc_src  (mem_pc_src),
        .mem_busy    (mem_busy),
        .pc_write    (pc_write),
        .ifid_write  (ifid_write),
        .ifid_flush  (ifid_flush),
        .idex_bubble (idex_bubble),
        .exmem_flush (exmem_flush),
        .pipe_freeze (pipe_freeze),
        .state       (state),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int pc_write;
        int ifid_write;
        int ifid_flush;
        int idex_bubble;
        int exmem_flush;
        int pipe_freeze;
        int state;
        int stall_cnt;
        int flush_cnt;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Model: state 0 INIT, 1 RUN, 2 STALL, 3 FLUSH; m_rule is the priority rule (1..5)
    bit   m_valid = 1'b0;
    int   m_state;
    int   m_hold;
    int   m_stall;
    int   m_flush;
    int   m_rule;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Advance the model across the edge that just occurred, using the inputs held during it
    task automatic model_edge();
        if (!rst_n) begin
            m_valid = 1'b1;
            m_state = 0;
            m_hold  = 0;
            m_stall = 0;
            m_flush = 0;
        end else if (m_valid) begin
            if (m_state == 0) begin
                if (m_hold == INIT_HOLD - 1) m_state = 1;
                if (m_hold < 15) m_hold = m_hold + 1;
            end else begin
                case (m_rule)
                    3: begin m_state = 3; m_flush = (m_flush + 1) % (1 << CNT_W); end
                    4: begin m_state = 2; m_stall = (m_stall + 1) % (1 << CNT_W); end
                    5: m_state = 1;
                    default: ;
                endcase
            end
        end
    endtask

    task automatic model_expect();
        exp_t e;
        bit   lu;
        if (!m_valid) return;
        lu = ex_mem_read && (ex_rt != 0) &&
             ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
        if (m_state == 0)    m_rule = 1;
        else if (mem_busy)   m_rule = 2;
        else if (mem_pc_src) m_rule = 3;
        else if (lu)         m_rule = 4;
        else                 m_rule = 5;
        e.pc_write    = (m_rule == 3 || m_rule == 5) ? 1 : 0;
        e.ifid_write  = (m_rule == 1 || m_rule == 3 || m_rule == 5) ? 1 : 0;
        e.ifid_flush  = (m_rule == 1 || m_rule == 3) ? 1 : 0;
        e.idex_bubble = (m_rule == 1 || m_rule == 3 || m_rule == 4) ? 1 : 0;
        e.exmem_flush = (m_rule == 1 || m_rule == 3) ? 1 : 0;
        e.pipe_freeze = (m_rule == 2) ? 1 : 0;
        e.state       = m_state;
`ifdef MIPS_HAZARD_PERF_EN
        e.stall_cnt   = m_stall;
        e.flush_cnt   = m_flush;
`else
        e.stall_cnt   = 0;
        e.flush_cnt   = 0;
`endif
        sb.push_back(e);
    endtask

    task automatic step(input logic r, input int rs, input int rt, input logic urt,
                        input logic mr, input int ert, input logic psrc, input logic busy);
        @(posedge clk);
        #1;
        model_edge();
        rst_n       = r;
        id_rs       = REG_W'(rs);
        id_rt       = REG_W'(rt);
        id_uses_rt  = urt;
        ex_mem_read = mr;
        ex_rt       = REG_W'(ert);
        mem_pc_src  = psrc;
        mem_busy    = busy;
        model_expect();
    endtask

    // Monitor: outputs are valid every cycle once reset has been seen
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("pc_write",    int'(pc_write),    e.pc_write);
                check("ifid_write",  int'(ifid_write),  e.ifid_write);
                check("ifid_flush",  int'(ifid_flush),  e.ifid_flush);
                check("idex_bubble", int'(idex_bubble), e.idex_bubble);
                check("exmem_flush", int'(exmem_flush), e.exmem_flush);
                check("pipe_freeze", int'(pipe_freeze), e.pipe_freeze);
                check("state",       int'(state),       e.state);
                check("stall_cnt",   int'(stall_cnt),   e.stall_cnt);
                check("flush_cnt",   int'(flush_cnt),   e.flush_cnt);
            end
        end
    end

    initial begin
        int drain;
        rst_n       = 1'b0;
        id_rs       = '0;
        id_rt       = '0;
        id_uses_rt  = 1'b0;
        ex_mem_read = 1'b0;
        ex_rt       = '0;
        mem_pc_src  = 1'b0;
        mem_busy    = 1'b0;

        // reset held 3 cycles, then init hold and run
        repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (4) step(1, 1, 2, 1, 0, 0, 0, 0);

        // single load-use stall, then resume
        step(1, 8, 0, 0, 1, 8, 0, 0);
        step(1, 8, 0, 0, 0, 0, 0, 0);
        // load to $zero and rt match without rt use: no stall
        step(1, 0, 0, 1, 1, 0, 0, 0);
        step(1, 3, 9, 0, 1, 9, 0, 0);
        // rt match with rt use: stall; back-to-back dependent load stalls again
        step(1, 3, 9, 1, 1, 9, 0, 0);
        step(1, 9, 4, 0, 1, 9, 0, 0);
        step(1, 1, 2, 0, 0, 0, 0, 0);

        // taken branch together with load-use: flush wins
        step(1, 8, 0, 0, 1, 8, 1, 0);
        step(1, 1, 2, 0, 0, 0, 0, 0);

        // busy for 3 cycles with a pending branch, then the flush
        repeat (3) step(1, 8, 0, 0, 1, 8, 1, 1);
        step(1, 1, 2, 0, 0, 0, 1, 0);
        step(1, 1, 2, 0, 0, 0, 0, 0);

        // reset during a stall cycle
        step(1, 5, 0, 0, 1, 5, 0, 0);
        step(0, 5, 0, 0, 1, 5, 0, 0);
        repeat (4) step(1, 1, 2, 0, 0, 0, 0, 0);

        // random traffic over a small register range to provoke matches
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) != 0),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 1) == 1),
                 int'($urandom_range(0, 3)), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 6) == 0));
        end

        drain = 0;
        while (sb.size() > 0 && drain < 20) begin
            @(posedge clk);
            drain++;
        end
        check("scoreboard_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
